branch_pc_unit: RTL and testbench
=================================

Name: branch_pc_unit

Overview:
- Consumer end of the ALU flag interface. Holds the committed N/V/Z flag register and the program counter.
- Evaluates 3-bit branch condition codes against the flags and redirects the PC for B, JAL, JR and HLT.
- Sits between EX (ALU result/flags) and IF (fetch address), and drives the one-cycle pipeline flush after every redirect.

Parameters:
- ASIZE, 16, PC/address width in words.
- OSIZE, 8, width of the signed branch/jump offset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- stall  in  1  pipeline stall; freezes PC and state.
- flag_in  in  3  ALU flags: [0]=N, [1]=V, [2]=Z.
- flag_update  in  1  the EX instruction writes flags this cycle.
- br_en  in  1  conditional branch presented this cycle.
- jal_en  in  1  jump-and-link presented.
- jr_en  in  1  jump-register presented.
- hlt_en  in  1  halt instruction presented.
- cond  in  3  branch condition code.
- br_pc  in  ASIZE  PC of the branch/jump instruction.
- offset  in  OSIZE  signed word offset.
- jr_target  in  ASIZE  register value for JR.
- pc_out  out  ASIZE  fetch address (registered).
- flush  out  1  registered; squash the wrong-path instruction.
- br_taken  out  1  registered; a redirect occurred last edge.
- ret_addr  out  ASIZE  registered link address for JAL.
- flags_out  out  3  committed flag register.
- halted  out  1  high in HALT state.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc_out=0, flags_out=000, flush=0, br_taken=0, ret_addr=0, halted=0, state=RUN.
  - Reset dominates everything, including mid-flush and HALT.
- States:
  - RUN: normal operation.
  - FLUSH: exactly one cycle after a redirect.
  - HALT: terminal; exits only via rst.
- Effective flags: eff = flag_update ? flag_in : flags_out. A flag-setting instruction in EX is forwarded to a same-cycle branch.
- Flag register:
  - On an edge with flag_update=1 and stall=0: flags_out <= flag_in.
  - This applies in RUN and FLUSH, and never in HALT.
- Condition codes, evaluated on eff:
  - 000 NEQ: Z=0.
  - 001 EQ: Z=1.
  - 010 GT: Z=0 and N=0.
  - 011 LT: N=1.
  - 100 GTE: Z=1 or (Z=0 and N=0).
  - 101 LTE: N=1 or Z=1.
  - 110 OVFL: V=1.
  - 111 UNCOND: always.
- Target arithmetic: rel = br_pc + 1 + sign_extend(offset), modulo 2^ASIZE (wraps silently). JR target = jr_target.
- RUN, stall=0, priority hlt_en > jr_en > jal_en > br_en > sequential:
  - hlt_en: state -> HALT, halted=1, pc_out holds.
  - jr_en: pc_out <= jr_target; flush=1, br_taken=1; state -> FLUSH.
  - jal_en: pc_out <= rel; ret_addr <= br_pc+1; flush=1, br_taken=1; state -> FLUSH.
  - br_en with condition true: pc_out <= rel; flush=1, br_taken=1; state -> FLUSH.
  - br_en with condition false: pc_out <= pc_out+1; no flush.
  - Otherwise: pc_out <= pc_out+1. 16'hFFFF wraps to 0.
- FLUSH (one cycle):
  - br_en, jal_en, jr_en and hlt_en are ignored (wrong-path instruction).
  - pc_out <= pc_out+1.
  - flush and br_taken return to 0.
  - state -> RUN.
- stall=1: pc_out, state, flush, br_taken, ret_addr and flags_out all hold. All control inputs are ignored; upstream re-presents them after the stall.
- HALT: all outputs hold; halted=1; inputs ignored.
- Multiple enables asserted together: resolved by the priority above; a lower-priority enable has no side effect (e.g., JR+JAL leaves ret_addr unchanged).
- Latency:
  - A redirect is visible on pc_out one edge after presentation.
  - flush/br_taken are high for exactly that following cycle.

Test Plan:
- Reset release, no inputs for 4 cycles -> pc_out 0,1,2,3,4; flush=0.
- flags_out=000; br_en=1, cond=001 (EQ), flag_update=1, flag_in=100, br_pc=0x0010, offset=0xFE:
  - Next edge: pc_out=0x000F, flush=1, br_taken=1, flags_out=100.
  - Following edge: flush=0, pc_out=0x0010.
- Condition not taken: flags_out=001 (N), br_en cond=010 (GT) -> pc_out increments by 1, flush stays 0. Repeat with cond=011 (LT) -> taken.
- JAL at br_pc=0xFFF0, offset=0x7F -> pc_out=0x0070 (wrap), ret_addr=0xFFF1. Then br_en=1, cond=111 presented during the FLUSH cycle -> ignored, pc_out=0x0071.
- stall=1 for 3 cycles with br_en=1, cond=111, flag_update=1 -> pc_out and flags_out unchanged. Then drop stall -> redirect taken.
- hlt_en=1 with jr_en=1 simultaneously -> halted=1, pc_out frozen for 10 cycles. Assert rst=0 mid-cycle -> pc_out=0 immediately, halted=0.

Source files
------------

// File: rtl/branch_pc_unit.sv
// Branch/PC unit: holds the committed N/V/Z flags and the fetch PC, resolves
// B/JAL/JR/HLT redirects and raises a one-cycle flush after every redirect.
module branch_pc_unit #(
  parameter int ASIZE = 16,
  parameter int OSIZE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [2:0]       flag_in,
  input  logic             flag_update,
  input  logic             br_en,
  input  logic             jal_en,
  input  logic             jr_en,
  input  logic             hlt_en,
  input  logic [2:0]       cond,
  input  logic [ASIZE-1:0] br_pc,
  input  logic [OSIZE-1:0] offset,
  input  logic [ASIZE-1:0] jr_target,
  output logic [ASIZE-1:0] pc_out,
  output logic             flush,
  output logic             br_taken,
  output logic [ASIZE-1:0] ret_addr,
  output logic [2:0]       flags_out,
  output logic             halted
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ASIZE-1:0] pc_q, pc_d;
  logic [ASIZE-1:0] ret_q, ret_d;
  logic [2:0]       flags_q, flags_d;
  logic             flush_q, flush_d;
  logic             taken_q, taken_d;

  logic [2:0]       eff_flags;
  logic             cond_true;
  logic [ASIZE-1:0] off_ext;
  logic [ASIZE-1:0] link_addr;
  logic [ASIZE-1:0] rel_target;

  // Same-cycle forwarding: a flag-setting EX instruction feeds the branch directly.
  assign eff_flags  = flag_update ? flag_in : flags_q;
  assign off_ext    = {{(ASIZE-OSIZE){offset[OSIZE-1]}}, offset};
  assign link_addr  = br_pc + ASIZE'(1);
  assign rel_target = link_addr + off_ext;

  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      3'b000:  cond_true = ~eff_flags[2];
      3'b001:  cond_true = eff_flags[2];
      3'b010:  cond_true = ~eff_flags[2] & ~eff_flags[0];
      3'b011:  cond_true = eff_flags[0];
      3'b100:  cond_true = eff_flags[2] | ~eff_flags[0];
      3'b101:  cond_true = eff_flags[0] | eff_flags[2];
      3'b110:  cond_true = eff_flags[1];
      default: cond_true = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      pc_q    <= '0;
      ret_q   <= '0;
      flags_q <= '0;
      flush_q <= 1'b0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ret_q   <= ret_d;
      flags_q <= flags_d;
      flush_q <= flush_d;
      taken_q <= taken_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ret_d   = ret_q;
    flags_d = flags_q;
    flush_d = flush_q;
    taken_d = taken_q;
    if (!stall && state_q != S_HALT) begin
      if (flag_update) flags_d = flag_in;
      flush_d = 1'b0;
      taken_d = 1'b0;
      if (state_q == S_FLUSH) begin
        // Wrong-path slot: every control enable is discarded.
        pc_d    = pc_q + ASIZE'(1);
        state_d = S_RUN;
      end else if (hlt_en) begin
        state_d = S_HALT;
      end else if (jr_en) begin
        pc_d    = jr_target;
        flush_d = 1'b1;
        taken_d = 1'b1;
        state_d = S_FLUSH;
      end else if (jal_en) begin
        pc_d    = rel_target;
        ret_d   = link_addr;
        flush_d = 1'b1;
        taken_d = 1'b1;
        state_d = S_FLUSH;
      end else if (br_en && cond_true) begin
        pc_d    = rel_target;
        flush_d = 1'b1;
        taken_d = 1'b1;
        state_d = S_FLUSH;
      end else begin
        pc_d = pc_q + ASIZE'(1);
      end
    end
  end

  always_comb begin
    pc_out    = pc_q;
    flush     = flush_q;
    br_taken  = taken_q;
    ret_addr  = ret_q;
    flags_out = flags_q;
    halted    = (state_q == S_HALT);
  end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Bench for branch_pc_unit: directed cycle table from reset, HALT/reset
// corner sequence, then random stimulus against a reference model.
module tb_branch_pc_unit;

  logic        clk, rst, stall, flag_update, br_en, jal_en, jr_en, hlt_en;
  logic [2:0]  flag_in, cond;
  logic [15:0] br_pc, jr_target;
  logic [7:0]  offset;
  logic [15:0] pc_out, ret_addr;
  logic        flush, br_taken, halted;
  logic [2:0]  flags_out;

  int cmp_cnt = 0;
  int err_cnt = 0;

  branch_pc_unit #(.ASIZE(16), .OSIZE(8)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flag_in(flag_in),
    .flag_update(flag_update), .br_en(br_en), .jal_en(jal_en),
    .jr_en(jr_en), .hlt_en(hlt_en), .cond(cond), .br_pc(br_pc),
    .offset(offset), .jr_target(jr_target), .pc_out(pc_out),
    .flush(flush), .br_taken(br_taken), .ret_addr(ret_addr),
    .flags_out(flags_out), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctl;   // {hlt, jr, jal, br}
    logic [2:0]  cnd;
    logic        st;
    logic        fu;
    logic [2:0]  fin;
    logic [15:0] bpc;
    logic [7:0]  off;
    logic [15:0] jrt;
    logic [15:0] e_pc;
    logic        e_fl;
    logic [15:0] e_ret;
    logic [2:0]  e_flg;
    logic        e_hlt;
  } vec_t;

  vec_t vt[21];

  function automatic vec_t mk(input logic [3:0] ctl, input logic [2:0] cnd,
                              input logic st, input logic fu, input logic [2:0] fin,
                              input logic [15:0] bpc, input logic [7:0] off,
                              input logic [15:0] jrt, input logic [15:0] e_pc,
                              input logic e_fl, input logic [15:0] e_ret,
                              input logic [2:0] e_flg, input logic e_hlt);
    vec_t v;
    v.ctl = ctl; v.cnd = cnd; v.st = st; v.fu = fu; v.fin = fin;
    v.bpc = bpc; v.off = off; v.jrt = jrt; v.e_pc = e_pc; v.e_fl = e_fl;
    v.e_ret = e_ret; v.e_flg = e_flg; v.e_hlt = e_hlt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] pc, input logic fl,
                     input logic bt, input logic [15:0] ret, input logic [2:0] flg,
                     input logic hl);
    logic [37:0] act, exp_v;
    act   = {pc_out, flush, br_taken, ret_addr, flags_out, halted};
    exp_v = {pc, fl, bt, ret, flg, hl};
    cmp_cnt++;
    if (act !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got pc=%h fl=%b bt=%b ret=%h flg=%b hlt=%b, want pc=%h fl=%b bt=%b ret=%h flg=%b hlt=%b",
               nm, pc_out, flush, br_taken, ret_addr, flags_out, halted, pc, fl, bt, ret, flg, hl);
    end
  endtask

  task automatic idle_inputs();
    stall = 0; flag_update = 0; flag_in = 0; br_en = 0; jal_en = 0;
    jr_en = 0; hlt_en = 0; cond = 0; br_pc = 0; offset = 0; jr_target = 0;
  endtask

  // Reference model state
  logic [15:0] m_pc, m_ret;
  logic [2:0]  m_flags;
  logic        m_fl, m_halt, m_wrong;

  task automatic model_reset();
    m_pc = 0; m_ret = 0; m_flags = 0; m_fl = 0; m_halt = 0; m_wrong = 0;
  endtask

  task automatic model_edge();
    logic [2:0] eff;
    logic       take;
    int         r;
    if (!m_halt && !stall) begin
      eff = flag_update ? flag_in : m_flags;
      if (flag_update) m_flags = flag_in;
      case (cond)
        3'd0: take = !eff[2];
        3'd1: take = eff[2];
        3'd2: take = !eff[2] && !eff[0];
        3'd3: take = eff[0];
        3'd4: take = eff[2] || (!eff[2] && !eff[0]);
        3'd5: take = eff[0] || eff[2];
        3'd6: take = eff[1];
        default: take = 1'b1;
      endcase
      r = int'(br_pc) + 1 + int'($signed(offset));
      if (m_wrong) begin
        m_pc = m_pc + 16'd1; m_fl = 0;
      end else if (hlt_en) begin
        m_halt = 1; m_fl = 0;
      end else if (jr_en) begin
        m_pc = jr_target; m_fl = 1;
      end else if (jal_en) begin
        m_pc = r[15:0]; m_ret = br_pc + 16'd1; m_fl = 1;
      end else if (br_en && take) begin
        m_pc = r[15:0]; m_fl = 1;
      end else begin
        m_pc = m_pc + 16'd1; m_fl = 0;
      end
      m_wrong = m_fl;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 0; idle_inputs();
    #1 chk("async_reset", 16'h0, 0, 0, 16'h0, 3'b0, 0);
    model_reset();
    @(negedge clk); rst = 1;
  endtask

  initial begin
    rst = 0;
    idle_inputs();
    vt[0]  = mk(4'b0000, 3'b000, 0, 0, 3'b000, 16'h0000, 8'h00, 16'h0000, 16'h0001, 0, 16'h0000, 3'b000, 0);
    vt[1]  = mk(4'b0000, 3'b000, 0, 0, 3'b000, 16'h0000, 8'h00, 16'h0000, 16'h0002, 0, 16'h0000, 3'b000, 0);
    vt[2]  = mk(4'b0000, 3'b000, 0, 0, 3'b000, 16'h0000, 8'h00, 16'h0000, 16'h0003, 0, 16'h0000, 3'b000, 0);
    vt[3]  = mk(4'b0000, 3'b000, 0, 0, 3'b000, 16'h0000, 8'h00, 16'h0000, 16'h0004, 0, 16'h0000, 3'b000, 0);
    vt[4]  = mk(4'b0001, 3'b001, 0, 1, 3'b100, 16'h0010, 8'hFE, 16'h0000, 16'h000F, 1, 16'h0000, 3'b100, 0);
    vt[5]  = mk(4'b0000, 3'b000, 0, 0, 3'b000, 16'h0000, 8'h00, 16'h0000, 16'h0010, 0, 16'h0000, 3'b100, 0);
    vt[6]  = mk(4'b0000, 3'b000, 0, 1, 3'b001, 16'h0000, 8'h00, 16'h0000, 16'h0011, 0, 16'h0000, 3'b001, 0);
    vt[7]  = mk(4'b0001, 3'b010, 0, 0, 3'b000, 16'h0030, 8'h10, 16'h0000, 16'h0012, 0, 16'h0000, 3'b001, 0);
    vt[8]  = mk(4'b0001, 3'b011, 0, 0, 3'b000, 16'h0020, 8'h05, 16'h0000, 16'h0026, 1, 16'h0000, 3'b001, 0);
    vt[9]  = mk(4'b0000, 3'b000, 0, 0, 3'b000, 16'h0000, 8'h00, 16'h0000, 16'h0027, 0, 16'h0000, 3'b001, 0);
    vt[10] = mk(4'b0010, 3'b000, 0, 0, 3'b000, 16'hFFF0, 8'h7F, 16'h0000, 16'h0070, 1, 16'hFFF1, 3'b001, 0);
    vt[11] = mk(4'b0001, 3'b111, 0, 0, 3'b000, 16'h0100, 8'h03, 16'h0000, 16'h0071, 0, 16'hFFF1, 3'b001, 0);
    vt[12] = mk(4'b0001, 3'b111, 1, 1, 3'b010, 16'h0200, 8'h10, 16'h0000, 16'h0071, 0, 16'hFFF1, 3'b001, 0);
    vt[13] = mk(4'b0001, 3'b111, 1, 1, 3'b010, 16'h0200, 8'h10, 16'h0000, 16'h0071, 0, 16'hFFF1, 3'b001, 0);
    vt[14] = mk(4'b0001, 3'b111, 1, 1, 3'b010, 16'h0200, 8'h10, 16'h0000, 16'h0071, 0, 16'hFFF1, 3'b001, 0);
    vt[15] = mk(4'b0001, 3'b111, 0, 1, 3'b010, 16'h0200, 8'h10, 16'h0000, 16'h0211, 1, 16'hFFF1, 3'b010, 0);
    vt[16] = mk(4'b0000, 3'b000, 0, 0, 3'b000, 16'h0000, 8'h00, 16'h0000, 16'h0212, 0, 16'hFFF1, 3'b010, 0);
    vt[17] = mk(4'b0110, 3'b000, 0, 0, 3'b000, 16'h0050, 8'h01, 16'hFFFE, 16'hFFFE, 1, 16'hFFF1, 3'b010, 0);
    vt[18] = mk(4'b0000, 3'b000, 0, 0, 3'b000, 16'h0000, 8'h00, 16'h0000, 16'hFFFF, 0, 16'hFFF1, 3'b010, 0);
    vt[19] = mk(4'b0000, 3'b000, 0, 0, 3'b000, 16'h0000, 8'h00, 16'h0000, 16'h0000, 0, 16'hFFF1, 3'b010, 0);
    vt[20] = mk(4'b1100, 3'b000, 0, 0, 3'b000, 16'h0000, 8'h00, 16'h1234, 16'h0000, 0, 16'hFFF1, 3'b010, 1);

    #2 chk("reset_state", 16'h0, 0, 0, 16'h0, 3'b0, 0);
    #10 rst = 1;

    for (int i = 0; i < 21; i++) begin
      {hlt_en, jr_en, jal_en, br_en} = vt[i].ctl;
      cond = vt[i].cnd; stall = vt[i].st; flag_update = vt[i].fu;
      flag_in = vt[i].fin; br_pc = vt[i].bpc; offset = vt[i].off;
      jr_target = vt[i].jrt;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), vt[i].e_pc, vt[i].e_fl, vt[i].e_fl,
          vt[i].e_ret, vt[i].e_flg, vt[i].e_hlt);
      $display("vec %0d: pc=%h flush=%b br_taken=%b ret=%h flags=%b halted=%b",
               i, pc_out, flush, br_taken, ret_addr, flags_out, halted);
    end

    // HALT is terminal: all inputs ignored for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      jr_en = 1; jal_en = $urandom_range(0, 1); br_en = 1; cond = 3'b111;
      flag_update = 1; flag_in = 3'($urandom); hlt_en = 0;
      stall = $urandom_range(0, 1); jr_target = 16'($urandom);
      br_pc = 16'($urandom); offset = 8'($urandom);
      @(posedge clk); #1;
      chk($sformatf("halt_hold%0d", i), 16'h0000, 0, 0, 16'hFFF1, 3'b010, 1);
      $display("halt %0d: pc=%h halted=%b", i, pc_out, halted);
    end

    // Reset dominates HALT, applied mid-cycle.
    do_reset();

    for (int i = 0; i < 800; i++) begin
      stall       = ($urandom_range(0, 3) == 0);
      flag_update = $urandom_range(0, 1);
      flag_in     = 3'($urandom);
      br_en       = $urandom_range(0, 1);
      jal_en      = ($urandom_range(0, 7) == 0);
      jr_en       = ($urandom_range(0, 7) == 0);
      hlt_en      = ($urandom_range(0, 31) == 0);
      cond        = 3'($urandom);
      br_pc       = 16'($urandom);
      offset      = 8'($urandom);
      jr_target   = 16'($urandom);
      model_edge();
      @(posedge clk); #1;
      chk($sformatf("rand%0d", i), m_pc, m_fl, m_fl, m_ret, m_flags, m_halt);
      if (m_halt && $urandom_range(0, 3) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
